grid_paint_ctrl: RTL and testbench
==================================

# grid_paint_ctrl

Parametrised edit controller between the keypad scanner, the debounced switch inputs and the colour register bank feeding the VGA tile renderer. It generalises the manual switch-address/commit write path into a cursor-driven editor over a GRID_COLS-wide grid with selectable colour depth. It supports two input modes (keypad cursor or direct switch address) and an optional clear-all sweep. It is the sole write master of the colour bank.

## Interface
- ADDR_W, 4, cell address width
- DATA_W, 3, colour width (bits per cell)
- CELLS, 16, number of cells; CELLS <= 2**ADDR_W, CELLS multiple of GRID_COLS
- GRID_COLS, 4, cells per grid row
- DEB_CYCLES, 500000, stable cycles required by switch debounce
- DEF_COLOR, 7, colour register value after reset
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- key_valid  in  1  one-cycle strobe from keypad scanner
- key_code  in  4  keypad code, valid with key_valid
- mode  in  1  0 = keypad cursor mode, 1 = switch-address mode
- sw_addr  in  ADDR_W  raw switch address, asynchronous
- sw_commit  in  1  raw commit button, asynchronous
- wr_en  out  1  bank write strobe
- wr_addr  out  ADDR_W  bank write address
- wr_data  out  DATA_W  bank write data
- cursor  out  ADDR_W  current cursor cell, for renderer highlight
- color  out  DATA_W  current paint colour
- busy  out  1  high while the clear sweep runs

## Operation
- States: IDLE, PAINT, CLEAR, SW_WR.
- IDLE, key_valid, code < 2**DATA_W and code <= 0x9 -> color <= code[DATA_W-1:0], in either mode.
- Mode 0 only: 0xA left, 0xB right, 0xC up, 0xD down move the cursor; 0xE -> PAINT.
- Cursor arithmetic, modulo CELLS:
  - right = cursor+1, wraps CELLS-1 -> 0; left wraps 0 -> CELLS-1.
  - up = cursor-GRID_COLS, plus CELLS on underflow; down = cursor+GRID_COLS, minus CELLS if >= CELLS.
- PAINT: one cycle, wr_en=1, wr_addr=cursor, wr_data=color -> IDLE.
- 0xF (mode-independent) -> CLEAR: writes wr_data=0 to addresses 0..CELLS-1, one per cycle, busy=1 throughout -> IDLE.
- Switch path: sw_addr and sw_commit each pass a 2-FF synchroniser plus a debounce counter; output changes only after DEB_CYCLES consecutive equal samples.
- Mode 1 only: rising edge of debounced commit in IDLE -> SW_WR, one cycle, wr_addr=debounced sw_addr, wr_data=color -> IDLE.
- Dropped events (no queue):
  - key_valid or commit edge while not IDLE;
  - codes with no defined action;
  - commit edge in mode 0.
- Same-cycle colour select and commit edge: the write uses the old colour.
- Mode change mid-CLEAR does not abort the sweep.
- Reset: any state -> IDLE immediately. Reset values: wr_en=0, wr_addr=0, wr_data=0, cursor=0, color=DEF_COLOR, busy=0. Debounce counters and the debounced commit clear to 0.

## Timing
- All outputs registered.
- key_valid at edge t: cursor/color updated at t+1; the PAINT write occurs in cycle t+1 with wr_en=1.
- CLEAR with 0xF at t: wr_en=1 and busy=1 for cycles t+1..t+CELLS, wr_addr=k in cycle t+1+k; busy=0 at t+CELLS+1.
- Commit: from a raw edge to wr_en = 2 (sync) + DEB_CYCLES + 1 (edge detect) + 1 cycles.
- wr_en is never high for two cycles, except during CLEAR.

## Configuration
- GRID_PAINT_CLEAR_EN defined: 0xF runs the CLEAR sweep as above.
- Undefined: CLEAR state and sweep counter are not built; 0xF is ignored; busy is tied 0.

## Structure
- Shared package holds:
  - the key code constants (KEY_LEFT=4'hA, KEY_RIGHT=4'hB, KEY_UP=4'hC, KEY_DOWN=4'hD, KEY_PAINT=4'hE, KEY_CLEAR=4'hF);
  - the state encoding typedef.
- One sub-module, sync_debounce #(W, DEB_CYCLES): 2-FF synchroniser plus stability counter. Instantiated once with W=ADDR_W+1 (address and commit together).

## Test plan
- Reset with defaults -> cursor=0, color=7, wr_en=0; key 0x3 then 0xE -> color=3, one wr_en pulse with addr 0, data 3.
- Cursor at 0: 0xA -> 15; 0xC from 1 -> 13; 0xD from 14 -> 2; 0xB from 15 -> 0.
- 0xF -> 16 consecutive writes of data 0, addr 0..15; busy high exactly 16 cycles; a key_valid mid-sweep is dropped.
- Mode 1, DEB_CYCLES=4, sw_addr=9, commit held high -> single write addr 9, data=color after 2+4+1+1 cycles; a 3-cycle glitch produces no write.
- Assert rst during CLEAR at k=5 -> wr_en=0 and busy=0 immediately; after release a fresh 0xF restarts at addr 0.
- Build without GRID_PAINT_CLEAR_EN -> 0xF produces no write and busy stays 0.

Source files
------------

// File: rtl/grid_paint_ctrl_pkg.sv
// Shared definitions for the grid paint editor: keypad codes, FSM encoding
// and the colour-key decode helper.
package grid_paint_ctrl_pkg;

  localparam logic [3:0] KEY_LEFT  = 4'hA;
  localparam logic [3:0] KEY_RIGHT = 4'hB;
  localparam logic [3:0] KEY_UP    = 4'hC;
  localparam logic [3:0] KEY_DOWN  = 4'hD;
  localparam logic [3:0] KEY_PAINT = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;

  localparam logic [3:0] KEY_MAX_COLOR = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2,
    SW_WR = 2'd3
  } state_e;

  // A digit key selects a colour only if it fits in the colour register.
  function automatic logic is_color_code(input logic [3:0] code, input int data_w);
    return (code <= KEY_MAX_COLOR) && (int'(code) < (1 << data_w));
  endfunction

endpackage

// File: rtl/grid_paint_ctrl_sync_debounce.sv
// Two-flop synchroniser followed by a stability filter: the output takes a
// new value only after it has been sampled DEB_CYCLES times in a row.
module sync_debounce #(
  parameter int W          = 1,
  parameter int DEB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [W-1:0]     meta;
  logic [W-1:0]     sync;
  logic [W-1:0]     cand;
  logic [CNT_W-1:0] cnt;

  // cnt holds how many consecutive samples have matched cand (and differ from dout).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      cand <= '0;
      cnt  <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      sync <= meta;
      if (sync == dout) begin
        cnt <= '0;
      end else if (sync != cand) begin
        cand <= sync;
        if (CNT_LAST == '0) begin
          dout <= sync;
          cnt  <= '0;
        end else begin
          cnt <= CNT_W'(1);
        end
      end else if (cnt == CNT_LAST) begin
        dout <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/grid_paint_ctrl.sv
// Cursor-driven colour-bank editor; sole write master of the colour bank.
// Define GRID_PAINT_CLEAR_EN to build the 0xF clear-all sweep.
module grid_paint_ctrl
  import grid_paint_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 3,
  parameter int CELLS      = 16,
  parameter int GRID_COLS  = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int DEF_COLOR  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              mode,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic              sw_commit,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] cursor,
  output logic [DATA_W-1:0] color,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(GRID_COLS);
  localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(CELLS - GRID_COLS);

  // key_valid is a one-cycle strobe with no back-pressure: it and the
  // debounced commit edge are acted on only in IDLE and dropped otherwise.

  state_e            state, state_n;
  logic [ADDR_W-1:0] cursor_n;
  logic [DATA_W-1:0] color_n;
  logic              wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [DATA_W-1:0] wr_data_n;

  logic [ADDR_W:0]   deb_out;
  logic [ADDR_W-1:0] deb_addr;
  logic              deb_commit;
  logic              commit_prev;
  logic              commit_rise;

  logic [ADDR_W-1:0] cur_left, cur_right, cur_up, cur_down;

  sync_debounce #(
    .W          (ADDR_W + 1),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sync_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  ({sw_addr, sw_commit}),
    .dout (deb_out)
  );

  assign deb_addr   = deb_out[ADDR_W:1];
  assign deb_commit = deb_out[0];

  // Cursor moves wrap around the grid in both axes.
  assign cur_right = (cursor == LAST_CELL) ? '0 : cursor + ADDR_W'(1);
  assign cur_left  = (cursor == '0) ? LAST_CELL : cursor - ADDR_W'(1);
  assign cur_up    = (int'(cursor) < GRID_COLS) ? cursor + WRAP_STEP : cursor - ROW_STEP;
  assign cur_down  = (int'(cursor) >= CELLS - GRID_COLS) ? cursor - WRAP_STEP
                                                        : cursor + ROW_STEP;

`ifdef GRID_PAINT_CLEAR_EN
  logic busy_n;
`endif

  always_comb begin
    state_n   = state;
    cursor_n  = cursor;
    color_n   = color;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
`ifdef GRID_PAINT_CLEAR_EN
    busy_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (key_valid) begin
          if (is_color_code(key_code, DATA_W)) begin
            color_n = DATA_W'(key_code);
          end
`ifdef GRID_PAINT_CLEAR_EN
          if (key_code == KEY_CLEAR) begin
            state_n   = CLEAR;
            wr_en_n   = 1'b1;
            wr_addr_n = '0;
            wr_data_n = '0;
            busy_n    = 1'b1;
          end else
`endif
          if (!mode) begin
            case (key_code)
              KEY_LEFT:  cursor_n = cur_left;
              KEY_RIGHT: cursor_n = cur_right;
              KEY_UP:    cursor_n = cur_up;
              KEY_DOWN:  cursor_n = cur_down;
              KEY_PAINT: begin
                state_n   = PAINT;
                wr_en_n   = 1'b1;
                wr_addr_n = cursor;
                wr_data_n = color;
              end
              default: ;
            endcase
          end
        end
        // Uses the pre-update colour when a colour key lands in the same cycle.
        if (mode && commit_rise && (state_n == IDLE)) begin
          state_n   = SW_WR;
          wr_en_n   = 1'b1;
          wr_addr_n = deb_addr;
          wr_data_n = color;
        end
      end
      PAINT, SW_WR: state_n = IDLE;
`ifdef GRID_PAINT_CLEAR_EN
      CLEAR: begin
        if (wr_addr == LAST_CELL) begin
          state_n = IDLE;
        end else begin
          wr_en_n   = 1'b1;
          wr_addr_n = wr_addr + ADDR_W'(1);
          wr_data_n = '0;
          busy_n    = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cursor      <= '0;
      color       <= DATA_W'(DEF_COLOR);
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      commit_prev <= 1'b0;
      commit_rise <= 1'b0;
    end else begin
      state       <= state_n;
      cursor      <= cursor_n;
      color       <= color_n;
      wr_en       <= wr_en_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      commit_prev <= deb_commit;
      commit_rise <= deb_commit & ~commit_prev;
    end
  end

`ifdef GRID_PAINT_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= busy_n;
  end
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_grid_paint_ctrl.sv
// Self-checking bench for grid_paint_ctrl: directed steps plus random keypad
// traffic against a modular-arithmetic reference model and a write scoreboard.
module tb_grid_paint_ctrl;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 3;
  localparam int CELLS     = 16;
  localparam int GRID_COLS = 4;
  localparam int DEB       = 4;
  localparam int DEF_COLOR = 7;
  localparam int W         = ADDR_W + DATA_W;

  logic              clk;
  logic              rst;
  logic              key_valid;
  logic [3:0]        key_code;
  logic              mode;
  logic [ADDR_W-1:0] sw_addr;
  logic              sw_commit;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] cursor;
  logic [DATA_W-1:0] color;
  logic              busy;

  grid_paint_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CELLS      (CELLS),
    .GRID_COLS  (GRID_COLS),
    .DEB_CYCLES (DEB),
    .DEF_COLOR  (DEF_COLOR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .mode      (mode),
    .sw_addr   (sw_addr),
    .sw_commit (sw_commit),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cursor    (cursor),
    .color     (color),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  int total = 0;
  int bad   = 0;
  int m_cursor;
  int m_color;

  always @(posedge clk) begin
    if (wr_en) act_q.push_back({wr_addr, wr_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic compare_writes();
    logic [W-1:0] e, a;
    idle(3);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      check("wr_seq", a, e);
    end
    check("wr_count_left", act_q.size(), exp_q.size());
    exp_q.delete();
    act_q.delete();
  endtask

  // driver: one key strobe (called aligned to a negedge, returns aligned)
  task automatic press(input logic [3:0] code);
    bit do_wr;
    int wa, wd;
    do_wr = 0;
    wa = m_cursor;
    wd = m_color;
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    if (code <= 4'h9 && int'(code) < (1 << DATA_W)) m_color = int'(code);
    if (!mode) begin
      case (code)
        4'hA: m_cursor = (m_cursor + CELLS - 1) % CELLS;
        4'hB: m_cursor = (m_cursor + 1) % CELLS;
        4'hC: m_cursor = (m_cursor - GRID_COLS + CELLS) % CELLS;
        4'hD: m_cursor = (m_cursor + GRID_COLS) % CELLS;
        4'hE: do_wr = 1;
        default: ;
      endcase
    end
    check("key_cursor", cursor, m_cursor);
    check("key_color", color, m_color);
    check("key_busy", busy, 0);
    check("key_wr_en", wr_en, do_wr);
    if (do_wr) begin
      check("paint_addr", wr_addr, wa);
      check("paint_data", wr_data, wd);
      exp_q.push_back({ADDR_W'(wa), DATA_W'(wd)});
      @(negedge clk);
      check("paint_single", wr_en, 0);
    end
  endtask

  initial begin
    int n;
    bit found;
    int old_color;
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    mode = 1'b0;
    sw_addr = '0;
    sw_commit = 1'b0;
    m_cursor = 0;
    m_color = DEF_COLOR;
    idle(3);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cursor", cursor, 0);
    check("rst_color", color, DEF_COLOR);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    idle(2);

    // colour select then paint at cursor 0
    press(4'h3);
    press(4'hE);
    compare_writes();

    // cursor wrap cases
    press(4'hA); check("left_wrap", cursor, 15);
    press(4'hB); press(4'hB); check("at_one", cursor, 1);
    press(4'hC); check("up_wrap", cursor, 13);
    press(4'hB); check("at_14", cursor, 14);
    press(4'hD); check("down_wrap", cursor, 2);
    press(4'hC); press(4'hB); check("at_15", cursor, 15);
    press(4'hB); check("right_wrap", cursor, 0);

    // random keypad traffic (0x0..0xE), occasional mode flips
    for (int i = 0; i < 60; i++) begin
      mode = ($urandom_range(0, 4) == 0);
      press(4'($urandom_range(0, 14)));
      idle($urandom_range(0, 2));
    end
    mode = 1'b0;
    compare_writes();

`ifdef GRID_PAINT_CLEAR_EN
    // full sweep with a key dropped mid-sweep
    key_valid = 1'b1;
    key_code = 4'hF;
    @(negedge clk);
    key_valid = 1'b0;
    for (int k = 0; k < CELLS; k++) begin
      check("clr_wr_en", wr_en, 1);
      check("clr_busy", busy, 1);
      check("clr_addr", wr_addr, k);
      check("clr_data", wr_data, 0);
      exp_q.push_back({ADDR_W'(k), DATA_W'(0)});
      if (k == 3) begin
        key_valid = 1'b1;
        key_code = 4'h5;
      end else begin
        key_valid = 1'b0;
      end
      @(negedge clk);
    end
    key_valid = 1'b0;
    check("clr_end_busy", busy, 0);
    check("clr_end_wr_en", wr_en, 0);
    check("clr_drop_key", color, m_color);
    compare_writes();

    // reset in the middle of a sweep
    key_valid = 1'b1;
    key_code = 4'hF;
    @(negedge clk);
    key_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({ADDR_W'(k), DATA_W'(0)});
      @(negedge clk);
    end
    check("rst_mid_addr", wr_addr, 5);
    rst = 1'b1;
    #1;
    check("rst_mid_wr_en", wr_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_color", color, DEF_COLOR);
    check("rst_mid_cursor", cursor, 0);
    m_color = DEF_COLOR;
    m_cursor = 0;
    @(negedge clk);
    rst = 1'b0;
    compare_writes();
    key_valid = 1'b1;
    key_code = 4'hF;
    @(negedge clk);
    key_valid = 1'b0;
    check("clr_restart_addr", wr_addr, 0);
    for (int k = 0; k < CELLS; k++) begin
      exp_q.push_back({ADDR_W'(k), DATA_W'(0)});
      @(negedge clk);
    end
    check("clr_restart_done", busy, 0);
    compare_writes();
`else
    // clear key ignored; reset still returns defaults mid-run
    press(4'hF);
    idle(4);
    check("noclr_busy", busy, 0);
    compare_writes();
    press(4'h5);
    press(4'hB);
    rst = 1'b1;
    #1;
    check("rst_mid_color", color, DEF_COLOR);
    check("rst_mid_cursor", cursor, 0);
    check("rst_mid_wr_en", wr_en, 0);
    m_color = DEF_COLOR;
    m_cursor = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(1);
`endif

    // switch-address commit, held high
    mode = 1'b1;
    sw_addr = 4'd9;
    sw_commit = 1'b1;
    n = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (wr_en) found = 1;
    end
    check("commit_latency", n, 2 + DEB + 1 + 1);
    check("commit_addr", wr_addr, 9);
    check("commit_data", wr_data, m_color);
    exp_q.push_back({ADDR_W'(9), DATA_W'(m_color)});
    @(posedge clk);
    #1;
    check("commit_single", wr_en, 0);
    @(negedge clk);
    idle(20);
    compare_writes();
    sw_commit = 1'b0;
    idle(12);

    // 3-cycle glitch must not commit
    sw_commit = 1'b1;
    idle(3);
    sw_commit = 1'b0;
    idle(15);
    compare_writes();

    // keypad in switch mode: colour only
    press(4'hE);
    press(4'hB);
    press(4'h2);
    compare_writes();

    // colour key in the same cycle as the commit edge: old colour written
    sw_addr = 4'd6;
    sw_commit = 1'b1;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    check("pre_commit_quiet", wr_en, 0);
    old_color = m_color;
    key_valid = 1'b1;
    key_code = 4'h4;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    m_color = 4;
    check("same_cyc_wr_en", wr_en, 1);
    check("same_cyc_addr", wr_addr, 6);
    check("same_cyc_data", wr_data, old_color);
    check("same_cyc_color", color, m_color);
    exp_q.push_back({ADDR_W'(6), DATA_W'(old_color)});
    @(negedge clk);
    sw_commit = 1'b0;
    idle(12);
    compare_writes();

    // commit edge in keypad mode is dropped
    mode = 1'b0;
    sw_commit = 1'b1;
    idle(12);
    sw_commit = 1'b0;
    idle(12);
    compare_writes();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
